// File: rtl/shift_unit_pipe_if.sv
// Handshake bus of shift_unit_pipe: request side (op, operands, tag) and result side.
// The master drives requests and out_ready; the slave (the shift unit) answers.
interface shift_unit_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [3:0]       alu_ctrl;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result_shift;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, rs1, rs2, alu_ctrl, in_tag, out_ready,
    input  in_ready, out_valid, result_shift, out_tag
  );

  modport slave (
    input  in_valid, rs1, rs2, alu_ctrl, in_tag, out_ready,
    output in_ready, out_valid, result_shift, out_tag
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA barrel shifter with valid/ready handshake, rd tag and flush.
// Define SHIFT_ROTATE_EN to build ROL/ROR; otherwise those encodings return 0.
module shift_unit_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  shift_unit_pipe_if.slave bus
);
  localparam int L = $clog2(XLEN);

  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_ROL = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;

  logic adv;
  logic accept;
  logic unused_rs2_hi;
  logic unused_tail;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: op_supported = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         op_supported = 1'b1;
`endif
      default:                op_supported = 1'b0;
    endcase
  endfunction

  // One barrel level: shift by 2^k. SRA refills from the sign captured at accept,
  // since the partial data's MSB is already sign-filled by earlier levels anyway.
  function automatic logic [XLEN-1:0] shift_level(input logic [XLEN-1:0] d,
                                                  input logic [3:0]      op,
                                                  input logic            sign,
                                                  input int              k);
    int              n;
    logic [XLEN-1:0] fill;
    n    = 1 << k;
    fill = {XLEN{sign}} << (XLEN - n);
    case (op)
      OP_SLL:  shift_level = d << n;
      OP_SRL:  shift_level = d >> n;
      OP_SRA:  shift_level = (d >> n) | fill;
`ifdef SHIFT_ROTATE_EN
      OP_ROL:  shift_level = (d << n) | (d >> (XLEN - n));
      OP_ROR:  shift_level = (d >> n) | (d << (XLEN - n));
`endif
      default: shift_level = d;
    endcase
  endfunction

  assign adv           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = adv && !flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign unused_rs2_hi = ^bus.rs2[XLEN-1:L];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             src_valid;
    logic [XLEN-1:0]  src_data;
    logic [L-1:0]     src_shamt;
    logic [3:0]       src_op;
    logic [TAG_W-1:0] src_tag;
    logic             src_sign;
    logic [XLEN-1:0]  data_d;

    logic             valid_q;
    logic [XLEN-1:0]  data_q;
    logic [L-1:0]     shamt_q;
    logic [3:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             sign_q;

    // Unsupported ops are zeroed on entry so every later level just passes zero along.
    if (s == 0) begin : g_src
      always_comb begin
        src_valid = accept;
        src_data  = op_supported(bus.alu_ctrl) ? bus.rs1 : '0;
        src_shamt = bus.rs2[L-1:0];
        src_op    = bus.alu_ctrl;
        src_tag   = bus.in_tag;
        src_sign  = bus.rs1[XLEN-1];
      end
    end else begin : g_src
      always_comb begin
        src_valid = g_stage[s-1].valid_q;
        src_data  = g_stage[s-1].data_q;
        src_shamt = g_stage[s-1].shamt_q;
        src_op    = g_stage[s-1].op_q;
        src_tag   = g_stage[s-1].tag_q;
        src_sign  = g_stage[s-1].sign_q;
      end
    end

    always_comb begin
      data_d = src_data;
      for (int k = 0; k < L; k++) begin
        if (((k * STAGES) / L) == s && src_shamt[k]) begin
          data_d = shift_level(data_d, src_op, src_sign, k);
        end
      end
    end

    // Whole pipe moves together on adv; flush only needs to kill the valid bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        op_q    <= '0;
        tag_q   <= '0;
        sign_q  <= 1'b0;
      end else begin
        if (flush) begin
          valid_q <= 1'b0;
        end else if (adv) begin
          valid_q <= src_valid;
        end
        if (adv) begin
          data_q  <= data_d;
          shamt_q <= src_shamt;
          op_q    <= src_op;
          tag_q   <= src_tag;
          sign_q  <= src_sign;
        end
      end
    end
  end

  assign bus.out_valid    = g_stage[STAGES-1].valid_q;
  assign bus.result_shift = g_stage[STAGES-1].data_q;
  assign bus.out_tag      = g_stage[STAGES-1].tag_q;
  assign unused_tail      = ^{g_stage[STAGES-1].shamt_q, g_stage[STAGES-1].op_q,
                              g_stage[STAGES-1].sign_q};
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed literal cases plus random traffic checked
// against a queue-based reference model (32-bit/2-stage and 64-bit/3-stage instances).
module tb_shift_unit_pipe;
  localparam int STAGES = 2;

  localparam logic [3:0] SLL = 4'b0101;
  localparam logic [3:0] SRL = 4'b0110;
  localparam logic [3:0] SRA = 4'b0111;
  localparam logic [3:0] ROL = 4'b1000;
  localparam logic [3:0] ROR = 4'b1001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic rst64 = 1'b1;
  logic flush64 = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [36:0] expQ[$];
  int          accQ[$];
  logic        prevHold = 1'b0;
  logic [31:0] prevResult;
  logic [4:0]  prevTag;

  shift_unit_pipe_if #(.XLEN(32), .TAG_W(5)) bus();
  shift_unit_pipe_if #(.XLEN(64), .TAG_W(5)) bus64();

  shift_unit_pipe #(.XLEN(32), .STAGES(STAGES), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  shift_unit_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst64), .flush(flush64), .bus(bus64)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelShift(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      SLL: return a << sh;
      SRL: return a >> sh;
      SRA: return 32'($signed(a) >>> sh);
`ifdef SHIFT_ROTATE_EN
      ROL: return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      ROR: return (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic [4:0] tag,
                               input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.rs1       = a;
    bus.rs2       = b;
    bus.alu_ctrl  = op;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic drive64(input logic iv, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [4:0] tag);
    @(negedge clk);
    bus64.in_valid  = iv;
    bus64.rs1       = a;
    bus64.rs2       = b;
    bus64.alu_ctrl  = op;
    bus64.in_tag    = tag;
    bus64.out_ready = 1'b1;
  endtask

  task automatic runSingle(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] tag,
                           input logic [31:0] expected);
    applyStimulus(1'b1, a, b, op, tag, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2 checkOutput({name, "_early"}, bus.out_valid, 64'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2;
    checkOutput({name, "_valid"}, bus.out_valid, 64'd1);
    checkOutput({name, "_result"}, bus.result_shift, expected);
    checkOutput({name, "_tag"}, bus.out_tag, tag);
  endtask

  // Scoreboard: every cycle, predict what will be accepted/consumed at the next edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      expQ.delete();
      accQ.delete();
      prevHold = 1'b0;
    end else begin
      checkOutput("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready) && !flush);
      if (prevHold) begin
        checkOutput("stall_hold_valid", bus.out_valid, 64'd1);
        checkOutput("stall_hold_result", bus.result_shift, prevResult);
        checkOutput("stall_hold_tag", bus.out_tag, prevTag);
      end
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", bus.out_valid, 64'd0);
        end else begin
          checkOutput("model_result", bus.result_shift, expQ[0][36:5]);
          checkOutput("model_tag", bus.out_tag, expQ[0][4:0]);
          checkOutput("min_latency", (cyc - accQ[0]) >= STAGES, 64'd1);
          if (bus.out_ready) begin
            void'(expQ.pop_front());
            void'(accQ.pop_front());
          end
        end
      end
      if (flush) begin
        expQ.delete();
        accQ.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        expQ.push_back({modelShift(bus.rs1, bus.rs2, bus.alu_ctrl), bus.in_tag});
        accQ.push_back(cyc);
      end
      prevHold   = bus.out_valid && !bus.out_ready && !flush;
      prevResult = bus.result_shift;
      prevTag    = bus.out_tag;
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.alu_ctrl = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.rs1 = '0; bus64.rs2 = '0; bus64.alu_ctrl = '0;
    bus64.in_tag = '0; bus64.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst64 = 1'b0;
    #2;
    checkOutput("reset_out_valid", bus.out_valid, 64'd0);
    checkOutput("reset_result", bus.result_shift, 64'd0);
    checkOutput("reset_tag", bus.out_tag, 64'd0);
    checkOutput("reset_in_ready", bus.in_ready, 64'd1);
    checkOutput("reset64_out_valid", bus64.out_valid, 64'd0);
    checkOutput("reset64_result", bus64.result_shift, 64'd0);

    runSingle("sll_basic", 32'h0000_000F, 32'd2, SLL, 5'd3, 32'h0000_003C);
    runSingle("sra_zero", 32'h8000_0001, 32'h0000_0020, SRA, 5'd1, 32'h8000_0001);
    runSingle("sll_max", 32'h0000_0003, 32'd31, SLL, 5'd2, 32'h8000_0000);
    runSingle("sra_max", 32'h8000_0000, 32'd31, SRA, 5'd4, 32'hFFFF_FFFF);
    runSingle("unsupported", 32'hDEAD_BEEF, 32'd3, 4'b0000, 5'd5, 32'h0000_0000);
`ifdef SHIFT_ROTATE_EN
    runSingle("ror_1", 32'h0000_0001, 32'd1, ROR, 5'd6, 32'h8000_0000);
    runSingle("rol_4", 32'h8000_0000, 32'd4, ROL, 5'd7, 32'h0000_0008);
`else
    runSingle("ror_1", 32'h0000_0001, 32'd1, ROR, 5'd6, 32'h0000_0000);
    runSingle("rol_4", 32'h8000_0000, 32'd4, ROL, 5'd7, 32'h0000_0000);
`endif

    // Back-to-back: one result per cycle, in order.
    applyStimulus(1'b1, 32'hF000_0000, 32'd4, SRL, 5'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hF000_0000, 32'd4, SRA, 5'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h8000_0001, 32'hFFFF_FFE1, SLL, 5'd4, 1'b1, 1'b0);
    #2 checkOutput("b2b_srl", bus.result_shift, 32'h0F00_0000);
    checkOutput("b2b_srl_tag", bus.out_tag, 5'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2 checkOutput("b2b_sra", bus.result_shift, 32'hFF00_0000);
    checkOutput("b2b_sra_tag", bus.out_tag, 5'd2);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2 checkOutput("b2b_sll", bus.result_shift, 32'h0000_0002);
    checkOutput("b2b_sll_valid", bus.out_valid, 64'd1);

    // Stall with two ops in flight.
    applyStimulus(1'b1, 32'h0000_00FF, 32'd4, SRL, 5'd10, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0001, 32'd31, SLL, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h1234_5678, 32'd8, SLL, 5'd12, 1'b0, 1'b0);
      #2 checkOutput("stall_in_ready", bus.in_ready, 64'd0);
      checkOutput("stall_result", bus.result_shift, 32'h0000_000F);
      checkOutput("stall_tag", bus.out_tag, 5'd10);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2 checkOutput("release_first", bus.result_shift, 32'h0000_000F);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2 checkOutput("release_second", bus.result_shift, 32'h8000_0000);
    checkOutput("release_second_tag", bus.out_tag, 5'd11);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
    #2 checkOutput("release_drained", bus.out_valid, 64'd0);

    // Flush with two ops in flight and a new op offered in the flush cycle.
    applyStimulus(1'b1, 32'hAAAA_AAAA, 32'd1, SRL, 5'd20, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h5555_5555, 32'd1, SLL, 5'd21, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'd0, SLL, 5'd22, 1'b0, 1'b1);
    #2 checkOutput("flush_in_ready", bus.in_ready, 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
      #2 checkOutput("flush_out_valid", bus.out_valid, 64'd0);
    end
    runSingle("post_flush", 32'h0000_1234, 32'd4, SLL, 5'd23, 32'h0001_2340);

    // 64-bit, 3-stage instance: latency, max SRA, and reset mid-flight.
    drive64(1'b1, 64'h8000_0000_0000_0000, 64'd63, SRA, 5'd7);
    drive64(1'b0, 64'h0, 64'h0, 4'h0, 5'h0);
    #2 checkOutput("x64_early1", bus64.out_valid, 64'd0);
    drive64(1'b0, 64'h0, 64'h0, 4'h0, 5'h0);
    #2 checkOutput("x64_early2", bus64.out_valid, 64'd0);
    drive64(1'b0, 64'h0, 64'h0, 4'h0, 5'h0);
    #2 checkOutput("x64_valid", bus64.out_valid, 64'd1);
    checkOutput("x64_sra_max", bus64.result_shift, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("x64_tag", bus64.out_tag, 5'd7);
    drive64(1'b1, 64'h0000_0000_0000_0001, 64'd1, SLL, 5'd9);
    drive64(1'b0, 64'h0, 64'h0, 4'h0, 5'h0);
    rst64 = 1'b1;
    drive64(1'b0, 64'h0, 64'h0, 4'h0, 5'h0);
    rst64 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 checkOutput("x64_rst_killed", bus64.out_valid, 64'd0);
      drive64(1'b0, 64'h0, 64'h0, 4'h0, 5'h0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      int          r;
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b[4:0] = 5'd0;
      else if (r == 1) b[4:0] = 5'd31;
      r = $urandom_range(0, 9);
      op = (r < 8) ? 4'(5 + (r % 5)) : 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 9) < 7, a, b, op, 5'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 5'h0, 1'b1, 1'b0);
      rst = 1'b0;
    end
    #2 checkOutput("drain_empty", expQ.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle 32-bit shift unit in the execute stage.
- Performs SLL/SRL/SRA, plus optional ROL/ROR, on XLEN-bit operands through a log2(XLEN)-level barrel shifter split across STAGES register stages.
- Uses a valid/ready handshake, carries a destination tag for writeback, and supports a flush from the hazard/branch unit.

Parameters:
- XLEN, 32, operand width; power of two, 32 or 64.
- STAGES, 2, register stages; 1..log2(XLEN). Latency = STAGES cycles.
- TAG_W, 5, width of the rd tag carried alongside each op.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  kill all in-flight ops this cycle.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts the op this cycle.
- rs1  input  XLEN  value to shift.
- rs2  input  XLEN  shift amount source; only rs2[log2(XLEN)-1:0] is used.
- alu_ctrl  input  4  0101 SLL, 0110 SRL, 0111 SRA, 1000 ROL, 1001 ROR.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result_shift  output  XLEN  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: all stage valid bits 0, out_valid 0, result_shift 0, out_tag 0. Reset mid-operation discards every in-flight op.
- Shift amount: shamt = rs2[log2(XLEN)-1:0]; upper bits of rs2 are ignored.
- Level split: level k (k = 0..L-1, L = log2(XLEN)) conditionally shifts by 2^k. Level k is placed in stage floor(k*STAGES/L), and each stage ends in a register. The last stage register drives result_shift and out_tag.
- Per-stage state: valid, partial data, remaining shamt bits, op, tag, and the sign bit rs1[XLEN-1] captured at accept.
- Fill rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the captured sign bit.
  - ROL/ROR wrap bits around.
- Unsupported alu_ctrl: accepted, flows through with normal latency, and produces result 0.
- Advance: adv = !out_valid || out_ready. When adv=1 all stages shift forward one slot; when adv=0 every stage holds (full stall, no bubble collapsing).
- Handshake:
  - in_ready = adv && !flush.
  - An op is accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - Data, tag and result_shift stay stable while out_valid && !out_ready.
- Throughput and latency: one op per cycle when out_ready stays high. An op accepted at edge N has out_valid=1 after edge N+STAGES-1 (STAGES=1: visible the cycle after accept).
- Flush: at the next edge all valid bits clear, including out_valid. No input is accepted in a flush cycle. Data registers need not clear. Flush while stalled also clears.
- Simultaneous rst and flush: rst wins; result is identical to reset.
- Zero shift: shamt=0 returns rs1 unchanged for every op.
- Maximum shift (shamt=XLEN-1):
  - SLL gives rs1[0] at the MSB.
  - SRA gives all sign bits (XLEN-1 of them) above rs1[XLEN-1].

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined: alu_ctrl 1000 = ROL, 1001 = ROR, same latency and handshake as the shift ops.
- Undefined: rotate hardware is not built; 1000 and 1001 fall into the unsupported path and return 0 with normal latency.

Test Plan:
- XLEN=32, STAGES=2, out_ready=1: rs1=0000000F, rs2=2, SLL, tag=3 -> after 2 cycles out_valid=1, result_shift=0000003C, out_tag=3.
- Back-to-back, out_ready=1:
  - SRL F0000000>>4 -> 0F000000.
  - SRA F0000000>>4 -> FF000000.
  - rs2=FFFFFFE1 (shamt=1), SLL 80000001 -> 00000002.
  - Expect one result per cycle, in order.
- Stall: hold out_ready=0 for 3 cycles with 2 ops in flight -> in_ready=0 and result_shift/out_tag stable. Release -> both results emerge in order, no loss or duplication.
- Flush with 2 ops in flight, plus in_valid=1 on the flush cycle -> next cycle out_valid=0 and neither op ever appears. A new op accepted afterwards completes normally.
- SHIFT_ROTATE_EN defined: ROR 00000001 by 1 -> 80000000; ROL 80000000 by 4 -> 00000008. Undefined: the same ops -> 00000000.
- XLEN=64, STAGES=3: SRA 8000000000000000 by 63 -> FFFFFFFFFFFFFFFF after 3 cycles. A rst pulse mid-flight -> out_valid=0 and that op is never emitted.
